// File: rtl/lock_access_supervisor.sv
// lock_access_supervisor: keypad-to-lock-core sequencer with cancel injection, fail counting and timed lockout.
// Optional ALARM_LATCH_EN keeps alarm set after lockout until the core reports unlocked.
module lock_access_supervisor #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic [3:0] core_state,
  output logic [3:0] core_key,
  output logic       lockout,
  output logic [2:0] fail_count,
  output logic       timeout_pulse,
  output logic       alarm
);
  typedef enum logic [2:0] {READY, CANCEL, SETTLE, LOCKOUT, WAITREL} state_t;
  state_t st_q, st_d;
  logic [3:0] s1_q, s2_q, prev_q, key_q, key_d;
  logic [2:0] fail_q, fail_d, fail_inc;
  logic lock_q, lock_d, tp_q, tp_d, flag_q, flag_d, press;
  logic [CNT_W-1:0] tcnt_q, tcnt_d, lcnt_q, lcnt_d;
  assign press = (s2_q != 4'hF) && (prev_q == 4'hF);
  assign fail_inc = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;
  always_comb begin
    st_d = st_q;
    key_d = 4'hF;
    lock_d = 1'b0;
    fail_d = fail_q;
    tp_d = 1'b0;
    flag_d = flag_q;
    tcnt_d = '0;
    lcnt_d = '0;
    case (st_q)
      READY: begin
        tcnt_d = (core_state inside {[4'd1:4'd3], [4'd6:4'd9]}) ? tcnt_q + CNT_W'(1) :
                 (core_state inside {4'd0, 4'd4, 4'd5}) ? '0 : tcnt_q;
        if (core_state == 4'd5) begin
          fail_d = fail_inc;
          flag_d = flag_q | ({29'd0, fail_inc} >= 32'(MAX_FAILS));
          key_d = 4'hD;
          st_d = CANCEL;
        end else if (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tp_d = 1'b1;
          key_d = 4'hD;
          st_d = CANCEL;
        end else if (press) begin
          key_d = s2_q;
          tcnt_d = '0;
        end
        if (core_state == 4'd4) fail_d = 3'd0;
      end
      CANCEL: st_d = SETTLE;
      SETTLE: begin
        st_d = flag_q ? LOCKOUT : READY;
        lock_d = flag_q;
        flag_d = 1'b0;
      end
      LOCKOUT: begin
        if (lcnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
          fail_d = 3'd0;
          st_d = WAITREL;
        end else begin
          lock_d = 1'b1;
          lcnt_d = lcnt_q + CNT_W'(1);
        end
      end
      WAITREL: st_d = (s2_q == 4'hF) ? READY : WAITREL;
      default: st_d = READY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= READY;
      s1_q <= 4'hF;
      s2_q <= 4'hF;
      prev_q <= 4'hF;
      key_q <= 4'hF;
      fail_q <= 3'd0;
      lock_q <= 1'b0;
      tp_q <= 1'b0;
      flag_q <= 1'b0;
      tcnt_q <= '0;
      lcnt_q <= '0;
    end else begin
      st_q <= st_d;
      s1_q <= key_in;
      s2_q <= s1_q;
      prev_q <= s2_q;
      key_q <= key_d;
      fail_q <= fail_d;
      lock_q <= lock_d;
      tp_q <= tp_d;
      flag_q <= flag_d;
      tcnt_q <= tcnt_d;
      lcnt_q <= lcnt_d;
    end
  end
  assign core_key = key_q;
  assign lockout = lock_q;
  assign fail_count = fail_q;
  assign timeout_pulse = tp_q;
`ifdef ALARM_LATCH_EN
  logic alarm_q;
  always_ff @(posedge clk) begin
    if (!rst_n) alarm_q <= 1'b0;
    else if (st_q == SETTLE && flag_q) alarm_q <= 1'b1;
    else if (st_q == READY && core_state == 4'd4) alarm_q <= 1'b0;
  end
  assign alarm = alarm_q;
`else
  assign alarm = lock_q;
`endif
endmodule

// File: tb/tb_lock_access_supervisor.sv
// tb_lock_access_supervisor: directed self-checking bench for lock_access_supervisor.
module tb_lock_access_supervisor;
`ifdef ALARM_LATCH_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] key_in = 4'hF, cs = 4'd0;
  logic [3:0] core_key;
  logic lockout, timeout_pulse, alarm;
  logic [2:0] fail_count;
  int n_cmp = 0, n_bad = 0;
  lock_access_supervisor #(.MAX_FAILS(3), .LOCKOUT_CYCLES(20), .TIMEOUT_CYCLES(10), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .core_state(cs), .core_key(core_key),
    .lockout(lockout), .fail_count(fail_count), .timeout_pulse(timeout_pulse), .alarm(alarm)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wrong();
    cs = 4'd5;
    tick();
    cs = 4'd0;
    tick();
    tick();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_key"}, {4'h0, core_key}, 8'h0F);
    chk({tag, "_lock"}, {7'd0, lockout}, 8'h00);
    chk({tag, "_fail"}, {5'd0, fail_count}, 8'h00);
    chk({tag, "_tp"}, {7'd0, timeout_pulse}, 8'h00);
    chk({tag, "_alarm"}, {7'd0, alarm}, 8'h00);
  endtask
  initial begin
    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;
    key_in = 4'h1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t1_key_c%0d", i), {4'h0, core_key}, (i == 3) ? 8'h01 : 8'h0F);
    end
    key_in = 4'hF;
    repeat (3) tick();
    cs = 4'd5;
    tick();
    chk("t2_fail", {5'd0, fail_count}, 8'd1);
    chk("t2_cancel", {4'h0, core_key}, 8'h0D);
    chk("t2_nolock", {7'd0, lockout}, 8'h00);
    cs = 4'd0;
    tick();
    chk("t2_after", {4'h0, core_key}, 8'h0F);
    tick();
    wrong();
    chk("t3_fail2", {5'd0, fail_count}, 8'd2);
    cs = 4'd5;
    tick();
    chk("t3_cancel3", {4'h0, core_key}, 8'h0D);
    chk("t3_fail3", {5'd0, fail_count}, 8'd3);
    cs = 4'd0;
    tick();
    chk("t3_settle_nolock", {7'd0, lockout}, 8'h00);
    key_in = 4'h2;
    tick();
    chk("t3_lock_entry", {7'd0, lockout}, 8'h01);
    chk("t3_alarm_entry", {7'd0, alarm}, 8'h01);
    for (int i = 2; i <= 20; i++) begin
      tick();
      chk($sformatf("t3_lock_c%0d", i), {7'd0, lockout}, 8'h01);
      chk($sformatf("t3_blk_c%0d", i), {4'h0, core_key}, 8'h0F);
    end
    tick();
    chk("t3_lock_exit", {7'd0, lockout}, 8'h00);
    chk("t3_fail_clr", {5'd0, fail_count}, 8'h00);
    chk("t3_alarm_exit", {7'd0, alarm}, {7'd0, AL});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_held_%0d", i), {4'h0, core_key}, 8'h0F);
    end
    key_in = 4'hF;
    repeat (4) tick();
    key_in = 4'h3;
    tick();
    tick();
    tick();
    chk("t3_new_press", {4'h0, core_key}, 8'h03);
    key_in = 4'hF;
    repeat (3) tick();
    wrong();
    wrong();
    chk("t4_fail_pre", {5'd0, fail_count}, 8'd2);
    cs = 4'd2;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("t4_idle_tp%0d", i), {7'd0, timeout_pulse}, 8'h00);
    end
    tick();
    chk("t4_tp", {7'd0, timeout_pulse}, 8'h01);
    chk("t4_cancel", {4'h0, core_key}, 8'h0D);
    chk("t4_fail_keep", {5'd0, fail_count}, 8'd2);
    cs = 4'd0;
    tick();
    chk("t4_tp_once", {7'd0, timeout_pulse}, 8'h00);
    chk("t4_key_f", {4'h0, core_key}, 8'h0F);
    tick();
    cs = 4'd4;
    tick();
    chk("t5_success_clr", {5'd0, fail_count}, 8'h00);
    chk("t5_alarm_clr", {7'd0, alarm}, 8'h00);
    cs = 4'd0;
    key_in = 4'h4;
    tick();
    tick();
    cs = 4'd5;
    tick();
    chk("t5_drop_key", {4'h0, core_key}, 8'h0D);
    chk("t5_drop_fail", {5'd0, fail_count}, 8'd1);
    cs = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_no_repress_%0d", i), {4'h0, core_key}, 8'h0F);
    end
    key_in = 4'hF;
    repeat (3) tick();
    wrong();
    wrong();
    chk("t6_fail3", {5'd0, fail_count}, 8'd3);
    repeat (3) tick();
    chk("t6_in_lock", {7'd0, lockout}, 8'h01);
    rst_n = 1'b0;
    tick();
    chk_reset("t6_rst");
    rst_n = 1'b1;
    tick();
    chk("t6_lock_gone", {7'd0, lockout}, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
